// File: rtl/imm_gen_if.sv
// Handshake bundle between decode (producer/consumer side) and the immediate FIFO.
// The slave modport is the imm_gen_pipe side.
interface imm_gen_if #(
  parameter int XLEN = 32,
  parameter int ERRW = 8
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic [2:0]      imm_src;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] imm;
  logic            fmt_err;
  logic [ERRW-1:0] err_cnt;

  modport master (
    output in_valid, instr, imm_src, out_ready,
    input  in_ready, out_valid, imm, fmt_err, err_cnt
  );

  modport slave (
    input  in_valid, instr, imm_src, out_ready,
    output in_ready, out_valid, imm, fmt_err, err_cnt
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// RISC-V immediate decoder feeding a DEPTH-entry FIFO with valid/ready on both sides.
// The head entry is held in output registers so imm/fmt_err come straight from flops.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int ERRW  = 8
) (
  input logic    clk,
  input logic    rst_n,
  imm_gen_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [XLEN-1:0] mem_imm [DEPTH];
  logic            mem_err [DEPTH];

  logic [AW-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [AW-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [AW:0]     count_reg, count_next;
  logic [XLEN-1:0] imm_reg;
  logic            fmt_err_reg;
  logic [ERRW-1:0] err_cnt_reg;

  logic            push, pop;
  logic [31:0]     raw;
  logic [XLEN-1:0] dec_imm;
  logic            dec_err;

  // 32-bit form of every immediate; shamt and illegal codes leave bit 31 clear.
  always_comb begin
    raw     = '0;
    dec_err = 1'b0;
    case (bus.imm_src)
      3'b000: raw = {{20{bus.instr[31]}}, bus.instr[31:20]};
      3'b001: raw = {{20{bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
      3'b010: raw = {{19{bus.instr[31]}}, bus.instr[31], bus.instr[7],
                     bus.instr[30:25], bus.instr[11:8], 1'b0};
      3'b011: raw = {{11{bus.instr[31]}}, bus.instr[31], bus.instr[19:12],
                     bus.instr[20], bus.instr[30:21], 1'b0};
      3'b100: raw = {bus.instr[31:12], 12'b0};
      3'b101: raw = (XLEN == 64) ? {26'b0, bus.instr[25:20]} : {27'b0, bus.instr[24:20]};
      default: dec_err = 1'b1;
    endcase
  end

  generate
    if (XLEN > 32) begin : g_wide
      assign dec_imm = {{(XLEN-32){raw[31]}}, raw};
    end else begin : g_narrow
      assign dec_imm = raw;
    end
  endgenerate

  assign bus.in_ready  = (count_reg != FULL);
  assign bus.out_valid = (count_reg != '0);
  assign bus.imm       = imm_reg;
  assign bus.fmt_err   = fmt_err_reg;
  assign bus.err_cnt   = err_cnt_reg;

  assign push        = bus.in_valid && bus.in_ready;
  assign pop         = bus.out_valid && bus.out_ready;
  assign rd_ptr_next = pop  ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
  assign wr_ptr_next = push ? wr_ptr_reg + 1'b1 : wr_ptr_reg;
  assign count_next  = count_reg + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

  always_ff @(posedge clk) begin
    if (push) begin
      mem_imm[wr_ptr_reg] <= dec_imm;
      mem_err[wr_ptr_reg] <= dec_err;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_reg  <= '0;
      wr_ptr_reg  <= '0;
      count_reg   <= '0;
      imm_reg     <= '0;
      fmt_err_reg <= 1'b0;
      err_cnt_reg <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
      // The new head is the entry being written now only when it lands in the head slot.
      if (count_next != '0) begin
        if (push && (rd_ptr_next == wr_ptr_reg)) begin
          imm_reg     <= dec_imm;
          fmt_err_reg <= dec_err;
        end else begin
          imm_reg     <= mem_imm[rd_ptr_next];
          fmt_err_reg <= mem_err[rd_ptr_next];
        end
      end
      if (push && dec_err && (err_cnt_reg != '1)) begin
        err_cnt_reg <= err_cnt_reg + 1'b1;
      end
    end
  end
endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, buffered successor to the combinational sign extender.
- Decodes every RV32/RV64 immediate format (I, S, B, J, U, I-shift) from a raw 32-bit instruction word.
- Places each result in a DEPTH-entry output FIFO with valid/ready handshakes on both sides.
- Sits between instruction fetch/decode and the execute stage of the pipelined core; lets decode run ahead while execute stalls.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64. The immediate is sign-extended to XLEN.
- DEPTH, 2, output FIFO entries; a power of two, at least 2.
- ERRW, 8, width of the saturating illegal-format counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  instr/imm_src are valid this cycle
- in_ready  out  1  block can accept an entry
- instr  in  32  raw instruction word
- imm_src  in  3  format select
- out_valid  out  1  FIFO head is valid
- out_ready  in  1  consumer takes the head this cycle
- imm  out  XLEN  decoded immediate at the FIFO head
- fmt_err  out  1  the head entry came from an illegal imm_src
- err_cnt  out  ERRW  count of accepted illegal entries, saturating

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is synchronous and active-low. All state changes happen on the rising edge of clk.
- Reset values (rst_n=0 at an edge):
  - read and write pointers, count, err_cnt = 0
  - out_valid = 0, imm = 0, fmt_err = 0
  - in_ready = 1 on the first cycle after reset is released
- Decode (combinational on the input side; s = instr[31] replicated):
  - 000 I: {s, instr[31:20]}
  - 001 S: {s, instr[31:25], instr[11:7]}
  - 010 B: {s, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}
  - 011 J: {s, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}
  - 100 U: {s, instr[31:12], 12'b0}; for XLEN=64, bit 31 is sign-extended into bits 63:32
  - 101 I-shift: shamt zero-extended; shamt is instr[24:20] for XLEN=32, instr[25:20] for XLEN=64
  - 110/111 illegal: decoded value 0, stored entry flag = 1
- Push: occurs when in_valid && in_ready. The decoded value and flag are written at the write pointer. Pointers wrap modulo DEPTH.
- Pop: occurs when out_valid && out_ready. The read pointer advances.
- in_ready = (count != DEPTH). It is driven only from registered count, with no combinational path from out_ready. A full FIFO therefore does not accept an entry in the same cycle as a pop.
- out_valid = (count != 0). imm and fmt_err are driven from the head entry. They must stay stable while out_valid && !out_ready.
- Latency: push at edge N on an empty FIFO gives out_valid=1 with that imm in the cycle after edge N (one cycle).
- Push and pop in the same cycle: count is unchanged, both pointers advance, order is preserved.
- When out_valid=0, imm and fmt_err hold their last value. They are 0 after reset.
- err_cnt increments by 1 on each accepted push with an illegal imm_src. It saturates at 2^ERRW-1. It is not affected by pops.
- in_valid while in_ready=0: no state change. The producer must hold its data.
- Reset mid-operation: all entries are discarded and every output returns to its reset value on that edge.

Test Plan:
- XLEN=32, push 0xFFF00093 with I (000) -> imm=0xFFFFFFFF, fmt_err=0, out_valid one cycle after accept.
- Back-to-back pushes with out_ready=1 -> imm sequence 0xFFFFFFFC, 0xFFFFFFF8, 0x00000008, 0x12345000, 0x0000001F, one result per cycle. Inputs:
  - 0xFE112E23 S (001)
  - 0xFE000CE3 B (010)
  - 0x008000EF J (011)
  - 0x123450B7 U (100)
  - 0x01F01013 I-shift (101)
- XLEN=64:
  - 0x800000B7 with U -> imm=0xFFFFFFFF80000000
  - 0x03F01013 with I-shift -> imm=0x000000000000003F
- Backpressure, DEPTH=2, out_ready=0, three pushes offered -> first two accepted and in_ready=0 while the third is held. Then raise out_ready -> outputs in push order, and the third is accepted one cycle after the first pop.
- Illegal codes: push 0x00000013 with 110, then with 111 -> two entries with imm=0 and fmt_err=1, err_cnt=2. With ERRW=2 and 5 illegal pushes -> err_cnt stops at 3.
- Reset mid-operation: FIFO holds 2 entries and err_cnt=1, assert rst_n=0 for one edge -> out_valid=0, imm=0, fmt_err=0, err_cnt=0, in_ready=1 the next cycle.
